// File: rtl/button_pkg.sv
// Shared constants for the button/LED channel bank.
package button_pkg;

    // Per-channel LED behaviour selected by MODE.
    localparam logic MODE_TOGGLE    = 1'b0;
    localparam logic MODE_MOMENTARY = 1'b1;

    // One millisecond of settling time at a 12 MHz system clock.
    localparam int DEBOUNCE_1MS_12MHZ = 32'd12000;

    // Level a released button reads on the board.
    function automatic logic released_level(input int active_low);
        logic lvl;
        if (active_low != 32'd0) begin
            lvl = 1'b1;
        end else begin
            lvl = 1'b0;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, counter debounce and accept events.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_12MHZ,
    parameter int ACTIVE_LOW      = 32'd1
) (
    input  logic CLK,
    input  logic RST,
    input  logic but,
    output logic stable_pressed,
    output logic press_evt,
    output logic release_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic             REL_LVL = released_level(ACTIVE_LOW);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stable_nxt_s;
    logic             accept_s;

    // Next counter / stable level: restart on agreement, accept after a full stable run.
    always_comb begin
        cnt_nxt_s    = CNT_ZERO;
        stable_nxt_s = stable_r;
        accept_s     = 1'b0;
        if (sync2_r == stable_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s    = CNT_ZERO;
            stable_nxt_s = sync2_r;
            accept_s     = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Synchroniser, debounce counter and accepted level registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_r  <= REL_LVL;
            sync2_r  <= REL_LVL;
            stable_r <= REL_LVL;
            cnt_r    <= CNT_ZERO;
        end else begin
            sync1_r  <= but;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Events fire combinationally on the accepting edge so the top can act on that edge.
    assign press_evt      = accept_s & (sync2_r != REL_LVL);
    assign release_evt    = accept_s & (sync2_r == REL_LVL);
    assign stable_pressed = (stable_r != REL_LVL);

endmodule

// File: rtl/button_toggle_bank.sv
// Bank of debounced buttons driving toggle/momentary LEDs and press strobes.
module button_toggle_bank
    import button_pkg::*;
#(
    parameter int CHANNELS        = 32'd4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_12MHZ,
    parameter int ACTIVE_LOW      = 32'd1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] BUT,
    input  logic [CHANNELS-1:0] MODE,
    output logic [CHANNELS-1:0] LED,
    output logic [CHANNELS-1:0] PRESS_PULSE
);

    logic [CHANNELS-1:0] stable_pressed_s;
    logic [CHANNELS-1:0] press_evt_s;
    logic [CHANNELS-1:0] release_evt_s;
    logic [CHANNELS-1:0] level_nxt_s;
    logic [CHANNELS-1:0] led_nxt_s;
    logic [CHANNELS-1:0] led_r;
    logic [CHANNELS-1:0] pulse_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .CLK            (CLK),
            .RST            (RST),
            .but            (BUT[g]),
            .stable_pressed (stable_pressed_s[g]),
            .press_evt      (press_evt_s[g]),
            .release_evt    (release_evt_s[g])
        );
    end

    // Next LED per channel: toggle on press, or follow the post-accept debounced level.
    always_comb begin
        level_nxt_s = {CHANNELS{1'b0}};
        led_nxt_s   = led_r;
        for (int i = 0; i < CHANNELS; i++) begin
            if (press_evt_s[i]) begin
                level_nxt_s[i] = 1'b1;
            end else if (release_evt_s[i]) begin
                level_nxt_s[i] = 1'b0;
            end else begin
                level_nxt_s[i] = stable_pressed_s[i];
            end
            if (MODE[i] == MODE_TOGGLE) begin
                if (press_evt_s[i]) begin
                    led_nxt_s[i] = ~led_r[i];
                end else begin
                    led_nxt_s[i] = led_r[i];
                end
            end else begin
                led_nxt_s[i] = level_nxt_s[i];
            end
        end
    end

    // LED and one-cycle press strobe registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            led_r   <= {CHANNELS{1'b0}};
            pulse_r <= {CHANNELS{1'b0}};
        end else begin
            led_r   <= led_nxt_s;
            pulse_r <= press_evt_s;
        end
    end

    assign LED         = led_r;
    assign PRESS_PULSE = pulse_r;

endmodule

// File: tb/tb_button_toggle_bank.sv
// Randomised and directed bench for button_toggle_bank against a run-length reference model.
module tb_button_toggle_bank;

    localparam int CH  = 2;
    localparam int DB  = 4;
    localparam logic REL = 1'b1;

    logic          CLK;
    logic          RST;
    logic [CH-1:0] BUT;
    logic [CH-1:0] MODE;
    logic [CH-1:0] LED;
    logic [CH-1:0] PRESS_PULSE;

    int n_checks;
    int n_errors;

    // Reference model: delay line of sampled inputs, mismatch run length, accepted level.
    logic dly0 [CH];
    logic dly1 [CH];
    logic m_stable [CH];
    int   m_run [CH];
    logic [CH-1:0] m_led;
    logic [CH-1:0] m_pulse;

    int pulse_cnt [CH];

    button_toggle_bank #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BUT         (BUT),
        .MODE        (MODE),
        .LED         (LED),
        .PRESS_PULSE (PRESS_PULSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            dly0[c] = REL;
            dly1[c] = REL;
            m_stable[c] = REL;
            m_run[c] = 0;
        end
        m_led = '0;
        m_pulse = '0;
    endtask

    // A new level is accepted once the synchronised input has disagreed with the
    // accepted level on DB consecutive edges.
    task automatic model_step();
        logic lvl;
        logic press;
        if (RST) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                lvl = dly1[c];
                dly1[c] = dly0[c];
                dly0[c] = BUT[c];
                press = 1'b0;
                if (lvl != m_stable[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DB) begin
                        m_stable[c] = lvl;
                        m_run[c] = 0;
                        press = (lvl != REL);
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_pulse[c] = press;
                if (MODE[c]) m_led[c] = (m_stable[c] != REL);
                else if (press) m_led[c] = ~m_led[c];
            end
        end
    endtask

    // One clock: model advances at the edge, DUT compared 1 time unit later, return at negedge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_eq("led_model", LED, m_led);
        check_eq("pulse_model", PRESS_PULSE, m_pulse);
        for (int c = 0; c < CH; c++) if (PRESS_PULSE[c]) pulse_cnt[c]++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check_eq("reset_led", LED, 32'd0);
        check_eq("reset_pulse", PRESS_PULSE, 32'd0);
        tick();
        RST = 1'b0;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) pulse_cnt[c] = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_counts();
        BUT  = 2'b11;
        MODE = 2'b00;
        RST  = 1'b1;
        #2;
        model_reset();
        check_eq("reset_async_led", LED, 32'd0);
        check_eq("reset_async_pulse", PRESS_PULSE, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int e = 0; e < 20; e++) tick();
        check_eq("idle_led", LED, 32'd0);

        // Clean toggle on channel 0.
        clear_counts();
        BUT = 2'b10;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq("toggle1_led0", LED[0], (e >= 6) ? 32'd1 : 32'd0);
            check_eq("toggle1_pulse0", PRESS_PULSE[0], (e == 6) ? 32'd1 : 32'd0);
        end
        BUT = 2'b11;
        for (int e = 0; e < 10; e++) tick();
        check_eq("release_keeps_led0", LED[0], 32'd1);
        BUT = 2'b10;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq("toggle2_led0", LED[0], (e >= 6) ? 32'd0 : 32'd1);
        end
        BUT = 2'b11;
        for (int e = 0; e < 10; e++) tick();
        check_eq("toggle_pulse_count", pulse_cnt[0], 32'd2);

        // Short glitch is rejected.
        clear_counts();
        BUT = 2'b10;
        for (int e = 0; e < 3; e++) tick();
        BUT = 2'b11;
        for (int e = 0; e < 10; e++) tick();
        check_eq("glitch_led0", LED[0], 32'd0);
        check_eq("glitch_pulses", pulse_cnt[0], 32'd0);

        // Bounce then hold: single press.
        BUT = 2'b10; tick();
        BUT = 2'b11; tick();
        BUT = 2'b10; tick();
        BUT = 2'b11; tick();
        BUT = 2'b10;
        for (int e = 0; e < 12; e++) tick();
        check_eq("bounce_pulses", pulse_cnt[0], 32'd1);
        check_eq("bounce_led0", LED[0], 32'd1);
        BUT = 2'b11;
        for (int e = 0; e < 10; e++) tick();

        // Momentary on channel 1.
        clear_counts();
        MODE = 2'b10;
        BUT = 2'b01;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq("mom_press_led1", LED[1], (e >= 6) ? 32'd1 : 32'd0);
        end
        BUT = 2'b11;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq("mom_release_led1", LED[1], (e >= 6) ? 32'd0 : 32'd1);
        end
        check_eq("mom_pulses", pulse_cnt[1], 32'd1);

        // Simultaneous presses from a cleared state.
        MODE = 2'b00;
        do_reset();
        BUT = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_eq("simul_led", LED, (e >= 6) ? 32'd3 : 32'd0);
            check_eq("simul_pulse", PRESS_PULSE, (e == 6) ? 32'd3 : 32'd0);
        end
        BUT = 2'b11;
        for (int e = 0; e < 10; e++) tick();

        // Reset mid-count with the button held through deassertion.
        do_reset();
        BUT = 2'b10;
        for (int e = 0; e < 3; e++) tick();
        do_reset();
        check_eq("midcount_led0", LED[0], 32'd0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_eq("held_reset_led0", LED[0], (e >= 6) ? 32'd1 : 32'd0);
        end
        BUT = 2'b11;
        for (int e = 0; e < 10; e++) tick();

        // Random traffic with occasional mode switches and resets.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5, 0) == 0) BUT[c] = ~BUT[c];
            end
            if ($urandom_range(60, 0) == 0) MODE = 2'($urandom_range(3, 0));
            if ($urandom_range(400, 0) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
